// File: rtl/lenet_pkg.sv
// Shared LeNet datapath constants: pixel width and the 2x2 window lane order
// used by both the window gatherer and the max-pool comparator.
package lenet_pkg;

  localparam int DATA_SIZE = 16;

  // Lane index within the packed window; lane n occupies [n*D +: D].
  localparam int LANE_BR = 0;
  localparam int LANE_BL = 1;
  localparam int LANE_TR = 2;
  localparam int LANE_TL = 3;

  function automatic logic [4*DATA_SIZE-1:0] pack_window(
    input logic [DATA_SIZE-1:0] tl,
    input logic [DATA_SIZE-1:0] tr,
    input logic [DATA_SIZE-1:0] bl,
    input logic [DATA_SIZE-1:0] br
  );
    logic [4*DATA_SIZE-1:0] w;
    w = '0;
    w[LANE_TL*DATA_SIZE +: DATA_SIZE] = tl;
    w[LANE_TR*DATA_SIZE +: DATA_SIZE] = tr;
    w[LANE_BL*DATA_SIZE +: DATA_SIZE] = bl;
    w[LANE_BR*DATA_SIZE +: DATA_SIZE] = br;
    return w;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer: single write port, two combinational read ports.
// Contents are not reset; every entry is rewritten on each even row before use.
module pool_line_buf #(
  parameter int DATA_SIZE = 16,
  parameter int IMG_W     = 28,
  parameter int AW        = $clog2(IMG_W)
) (
  input  logic                 clk,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [DATA_SIZE-1:0] wr_dat_i,
  input  logic [AW-1:0]        rd0_addr_i,
  output logic [DATA_SIZE-1:0] rd0_dat_o,
  input  logic [AW-1:0]        rd1_addr_i,
  output logic [DATA_SIZE-1:0] rd1_dat_o
);

  logic [DATA_SIZE-1:0] mem_q [IMG_W];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_dat_i;
    end
  end

  assign rd0_dat_o = mem_q[rd0_addr_i];
  assign rd1_dat_o = mem_q[rd1_addr_i];

endmodule

// File: rtl/pool_window_buf.sv
// Streaming 2x2 stride-2 window gatherer feeding the max-pool comparator; 1-cycle latency,
// in_ready = !out_valid | out_ready. Define POOL_WIN_BUF_RELU_EN to clamp negative pixels to 0.
module pool_window_buf #(
  parameter int DATA_SIZE = lenet_pkg::DATA_SIZE,
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_SIZE-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*DATA_SIZE-1:0] out_window,
  output logic                   out_last
);
  import lenet_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  generate
    if ((IMG_W % 2) != 0 || (IMG_H % 2) != 0 || IMG_W < 2 || IMG_H < 2) begin : g_bad_dims
      $error("pool_window_buf: IMG_W and IMG_H must be even and >= 2");
    end
  endgenerate

  logic [DATA_SIZE-1:0]   pix;
  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic [DATA_SIZE-1:0]   bl_q, bl_d;
  logic [4*DATA_SIZE-1:0] window_q, window_d, window_new;
  logic                   valid_q, valid_d;
  logic                   last_q, last_d;
  logic                   acc, col_last, row_last, win_ld;
  logic [DATA_SIZE-1:0]   lb_left, lb_right;

`ifdef POOL_WIN_BUF_RELU_EN
  assign pix = in_data[DATA_SIZE-1] ? '0 : in_data;
`else
  assign pix = in_data;
`endif

  assign in_ready = !valid_q | out_ready;
  assign acc      = in_valid & in_ready;
  assign col_last = (col_q == CW'(IMG_W - 1));
  assign row_last = (row_q == RW'(IMG_H - 1));
  assign win_ld   = acc & row_q[0] & col_q[0];

  // Left neighbour of an odd column is that column with bit 0 cleared.
  pool_line_buf #(
    .DATA_SIZE (DATA_SIZE),
    .IMG_W     (IMG_W),
    .AW        (CW)
  ) u_line_buf (
    .clk        (clk),
    .wr_en_i    (acc & ~row_q[0]),
    .wr_addr_i  (col_q),
    .wr_dat_i   (pix),
    .rd0_addr_i (col_q & ~CW'(1)),
    .rd0_dat_o  (lb_left),
    .rd1_addr_i (col_q),
    .rd1_dat_o  (lb_right)
  );

  always_comb begin
    window_new = '0;
    window_new[LANE_TL*DATA_SIZE +: DATA_SIZE] = lb_left;
    window_new[LANE_TR*DATA_SIZE +: DATA_SIZE] = lb_right;
    window_new[LANE_BL*DATA_SIZE +: DATA_SIZE] = bl_q;
    window_new[LANE_BR*DATA_SIZE +: DATA_SIZE] = pix;
  end

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    bl_d     = bl_q;
    window_d = window_q;
    last_d   = last_q;
    valid_d  = valid_q;
    if (acc) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      if (row_q[0] && !col_q[0]) begin
        bl_d = pix;
      end
    end
    // A fresh window wins over a same-cycle drain of the old one.
    if (win_ld) begin
      window_d = window_new;
      last_d   = row_last & col_last;
      valid_d  = 1'b1;
    end else if (out_ready) begin
      valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q    <= '0;
      row_q    <= '0;
      bl_q     <= '0;
      window_q <= '0;
      last_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      bl_q     <= bl_d;
      window_q <= window_d;
      last_q   <= last_d;
      valid_q  <= valid_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_window = window_q;
  assign out_last   = last_q;

endmodule
